// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types and default rule masks for the Game-of-Life row engine
package life_pkg;

  localparam logic [8:0] RULE_B3S23_BIRTH   = 9'b000001000;
  localparam logic [8:0] RULE_B3S23_SURVIVE = 9'b000001100;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

endpackage

// File: rtl/life_cell_rule.sv
// rtl/life_cell_rule.sv - next state of one cell from its 8 neighbours and the active rule masks
module life_cell_rule
  import life_pkg::*;
(
  input  logic [7:0] nbr_i,
  input  logic       self_i,
  input  logic [8:0] birth_mask_i,
  input  logic [8:0] survive_mask_i,
  output logic       next_o
);

  logic [3:0] live_cnt;

  always_comb begin
    live_cnt = '0;
    for (int k = 0; k < 8; k++) begin
      live_cnt = live_cnt + {3'b000, nbr_i[k]};
    end
  end

  assign next_o = self_i ? survive_mask_i[live_cnt] : birth_mask_i[live_cnt];

endmodule

// File: rtl/life_row_engine.sv
// rtl/life_row_engine.sv - streaming one-generation Game-of-Life engine, one row per handshake
module life_row_engine
  import life_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit WRAP  = 1'b0,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_row,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic [8:0]       birth_mask,
  input  logic [8:0]       survive_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_row,
  output logic             out_last,
  output logic             frame_err,
  output logic [GEN_W-1:0] gen_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d, cur_q, cur_d;
  logic [8:0]       birth_q, birth_d, surv_q, surv_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [WIDTH-1:0] out_row_q, out_row_d;
  logic             frame_err_q, frame_err_d;
  logic [GEN_W-1:0] gen_q, gen_d;

  logic             slot_free, accept;
  logic [WIDTH-1:0] below_row, next_row;
  logic [WIDTH+1:0] ext_a, ext_m, ext_b;

  assign slot_free = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  // While flushing, the row below the last row is the dead vertical edge.
  assign below_row = (state_q == RUN) ? in_row : '0;

  // Rows padded by one cell each side; padding is the opposite edge when wrapping.
  assign ext_a = {WRAP ? prev_q[0] : 1'b0, prev_q, WRAP ? prev_q[WIDTH-1] : 1'b0};
  assign ext_m = {WRAP ? cur_q[0] : 1'b0, cur_q, WRAP ? cur_q[WIDTH-1] : 1'b0};
  assign ext_b = {WRAP ? below_row[0] : 1'b0, below_row, WRAP ? below_row[WIDTH-1] : 1'b0};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    life_cell_rule u_cell (
      .nbr_i          ({ext_a[i], ext_a[i+1], ext_a[i+2], ext_m[i], ext_m[i+2],
                        ext_b[i], ext_b[i+1], ext_b[i+2]}),
      .self_i         (cur_q[i]),
      .birth_mask_i   (birth_q),
      .survive_mask_i (surv_q),
      .next_o         (next_row[i])
    );
  end

  always_comb begin
    case (state_q)
      IDLE:    in_ready = 1'b1;
      RUN:     in_ready = slot_free;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    birth_d     = birth_q;
    surv_d      = surv_q;
    out_valid_d = out_valid_q && !out_ready;
    out_row_d   = out_row_q;
    out_last_d  = out_last_q;
    frame_err_d = 1'b0;
    gen_d       = gen_q;
    if (out_valid_q && out_ready && out_last_q) begin
      gen_d = gen_q + GEN_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_sof) begin
            prev_d  = '0;
            cur_d   = in_row;
            birth_d = birth_mask;
            surv_d  = survive_mask;
            state_d = in_eof ? FLUSH : RUN;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_row_d   = next_row;
          out_last_d  = 1'b0;
          prev_d      = cur_q;
          cur_d       = in_row;
          frame_err_d = in_sof;
          if (in_eof) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_row_d   = next_row;
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      cur_q       <= '0;
      birth_q     <= RULE_B3S23_BIRTH;
      surv_q      <= RULE_B3S23_SURVIVE;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      gen_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      birth_q     <= birth_d;
      surv_q      <= surv_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
      gen_q       <= gen_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_life_row_engine.sv
// tb/tb_life_row_engine.sv - bench for life_row_engine, one clamped-edge and one wrapping instance
module tb_life_row_engine;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_row;
  logic       in_sof;
  logic       in_eof;
  logic [8:0] birth_mask;
  logic [8:0] survive_mask;
  logic       out_ready;

  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [7:0]  out_row0, out_row1;
  logic        out_last0, out_last1, frame_err0, frame_err1;
  logic [15:0] gen0, gen1;

  logic [7:0]  got0[$], got1[$];
  logic        last0[$], last1[$];
  int          tests, fails, fbase;
  bit          bp_en;
  logic [15:0] exp_gen;

  life_row_engine #(.WIDTH(8), .WRAP(1'b0), .GEN_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_row(in_row),
    .in_sof(in_sof), .in_eof(in_eof), .birth_mask(birth_mask), .survive_mask(survive_mask),
    .out_valid(out_valid0), .out_ready(out_ready), .out_row(out_row0), .out_last(out_last0),
    .frame_err(frame_err0), .gen_count(gen0)
  );

  life_row_engine #(.WIDTH(8), .WRAP(1'b1), .GEN_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_row(in_row),
    .in_sof(in_sof), .in_eof(in_eof), .birth_mask(birth_mask), .survive_mask(survive_mask),
    .out_valid(out_valid1), .out_ready(out_ready), .out_row(out_row1), .out_last(out_last1),
    .frame_err(frame_err1), .gen_count(gen1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready) begin
      got0.push_back(out_row0);
      last0.push_back(out_last0);
    end
    if (rst_n && out_valid1 && out_ready) begin
      got1.push_back(out_row1);
      last1.push_back(out_last1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next generation of row r, counting neighbours directly over the whole frame.
  function automatic logic [7:0] model_row(input logic [7:0] rows[$], input int r,
                                           input logic [8:0] b, input logic [8:0] s,
                                           input bit wrap);
    logic [7:0] res;
    int n, rr, cc;
    res = '0;
    for (int c = 0; c < 8; c++) begin
      n = 0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          rr = r + dr;
          cc = c + dc;
          if (wrap) cc = (cc + 8) % 8;
          if (!(dr == 0 && dc == 0) && rr >= 0 && rr < rows.size() && cc >= 0 && cc < 8)
            n += int'(rows[rr][cc]);
        end
      end
      res[c] = rows[r][c] ? s[n] : b[n];
    end
    return res;
  endfunction

  task automatic send_row(input logic [7:0] row, input logic sof, input logic eof);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_row   = row;
    in_sof   = sof;
    in_eof   = eof;
    if (bp_en) out_ready = 1'($urandom_range(0, 1));
    forever begin
      @(negedge clk);
      if (in_ready0) break;
      k++;
      if (k >= 200) break;
      @(posedge clk);
      #1;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end
    check("send_accept", in_ready0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  task automatic wait_outputs(input int target);
    int k;
    k = 0;
    while ((got0.size() < target || got1.size() < target) && k < 500) begin
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      k++;
    end
    out_ready = 1'b1;
    check("out_count0", got0.size(), target);
    check("out_count1", got1.size(), target);
  endtask

  task automatic run_frame(input logic [7:0] rows[$], input logic [8:0] b, input logic [8:0] s,
                           input logic [8:0] b2, input logic [8:0] s2);
    int h;
    h     = rows.size();
    fbase = got0.size();
    birth_mask   = b;
    survive_mask = s;
    for (int i = 0; i < h; i++) begin
      send_row(rows[i], i == 0, i == h - 1);
      if (i == 0) begin
        birth_mask   = b2;
        survive_mask = s2;
      end
    end
    wait_outputs(fbase + h);
    for (int i = 0; i < h; i++) begin
      if (fbase + i < got0.size()) begin
        check("row_clamp", got0[fbase+i], model_row(rows, i, b, s, 1'b0));
        check("last_clamp", last0[fbase+i], i == h - 1);
      end
      if (fbase + i < got1.size()) begin
        check("row_wrap", got1[fbase+i], model_row(rows, i, b, s, 1'b1));
        check("last_wrap", last1[fbase+i], i == h - 1);
      end
    end
    exp_gen = exp_gen + 16'd1;
    check("gen_clamp", gen0, exp_gen);
    check("gen_wrap", gen1, exp_gen);
  endtask

  task automatic check_const(input string tag, input bit use_wrap, input logic [7:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (!use_wrap && fbase + i < got0.size()) check(tag, got0[fbase+i], exp[i]);
      if (use_wrap && fbase + i < got1.size()) check(tag, got1[fbase+i], exp[i]);
    end
  endtask

  localparam logic [8:0] B3 = 9'b000001000;
  localparam logic [8:0] S23 = 9'b000001100;

  initial begin
    logic [7:0] rows[$];
    logic [7:0] exp[$];
    int sz, k, h;
    tests = 0; fails = 0; fbase = 0; bp_en = 1'b0; exp_gen = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_row = '0; in_sof = 1'b0; in_eof = 1'b0;
    birth_mask = B3; survive_mask = S23; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_out_row", out_row0, 8'h00);
    check("rst_out_last", out_last0, 1'b0);
    check("rst_frame_err", frame_err0, 1'b0);
    check("rst_gen", gen0, 16'h0);
    check("rst_in_ready", in_ready0, 1'b1);
    @(posedge clk);
    #1;

    rows = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h00};
    run_frame(rows, B3, S23, B3, S23);
    exp = '{8'h00, 8'h00, 8'h1C, 8'h00, 8'h00};
    check_const("blinker", 1'b0, exp);

    rows = '{8'h00, 8'h83, 8'h00};
    run_frame(rows, B3, S23, B3, S23);
    exp = '{8'h01, 8'h01, 8'h01};
    check_const("wrap_on", 1'b1, exp);
    exp = '{8'h00, 8'h00, 8'h00};
    check_const("wrap_off", 1'b0, exp);

    rows = '{8'hFF};
    run_frame(rows, B3, S23, B3, S23);
    exp = '{8'h7E};
    check_const("single_row", 1'b0, exp);

    rows = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h00};
    fork
      run_frame(rows, B3, S23, B3, S23);
      begin
        k = 0;
        do begin
          @(posedge clk);
          #1;
          k++;
        end while (!out_valid0 && k < 100);
        check("stall_seen", out_valid0, 1'b1);
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready0, 1'b0);
          check("stall_in_ready_w", in_ready1, 1'b0);
          check("stall_out_row", out_row0, 8'h00);
          check("stall_out_valid", out_valid0, 1'b1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    exp = '{8'h00, 8'h00, 8'h1C, 8'h00, 8'h00};
    check_const("stall_rows", 1'b0, exp);

    rows = '{8'h14};
    run_frame(rows, 9'b000000100, 9'h000, 9'b000000100, 9'h000);
    exp = '{8'h08};
    check_const("b2s_single", 1'b0, exp);
    rows = '{8'h00, 8'h14, 8'h00};
    run_frame(rows, 9'b000000100, 9'h000, B3, S23);
    exp = '{8'h08, 8'h08, 8'h08};
    check_const("mask_latched", 1'b0, exp);

    sz = got0.size();
    send_row(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    check("err_pulse", frame_err0, 1'b1);
    check("err_pulse_w", frame_err1, 1'b1);
    @(negedge clk);
    check("err_clear", frame_err0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("err_no_output", got0.size(), sz);
    check("err_idle_ready", in_ready0, 1'b1);

    birth_mask = B3; survive_mask = S23;
    send_row(8'h00, 1'b1, 1'b0);
    send_row(8'h08, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid0, 1'b0);
    check("mid_rst_ready", in_ready0, 1'b1);
    check("mid_rst_gen", gen0, 16'h0);
    exp_gen = '0;
    @(posedge clk);
    #1;
    rows = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h00};
    run_frame(rows, B3, S23, B3, S23);
    exp = '{8'h00, 8'h00, 8'h1C, 8'h00, 8'h00};
    check_const("post_rst", 1'b0, exp);

    bp_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      h = $urandom_range(1, 6);
      rows.delete();
      for (int i = 0; i < h; i++) rows.push_back(8'($urandom));
      run_frame(rows, 9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom));
    end
    bp_en = 1'b0;
    out_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
